// File: rtl/debug_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_pkg                                                    |
// | Description : Shared definitions for the host-side debug controller:       |
// |               command byte codes, controller state encoding, dump word     |
// |               index bounds and small elaboration-time helpers.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package debug_pkg;

  // Host command bytes (ASCII 'c', 's', 'r').
  localparam logic [7:0] CMD_RUN  = 8'h63;
  localparam logic [7:0] CMD_STEP = 8'h73;
  localparam logic [7:0] CMD_PRST = 8'h72;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_PRST = 3'd3,
    ST_LOAD = 3'd4,
    ST_CAPT = 3'd5,
    ST_SEND = 3'd6
  } state_t;

  // Dump word index layout: PC, cycle count, register file, data memory.
  localparam int WIDX_PC   = 0;
  localparam int WIDX_CNT  = 1;
  localparam int WIDX_REG0 = 2;

  // First data-memory word index depends on the register file depth.
  function automatic int widx_mem0(input int regfile_depth);
    return WIDX_REG0 + regfile_depth;
  endfunction

  // Ceiling log2, never less than one bit.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debug_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_unit_if                                                |
// | Description : Byte transmit handshake between the debug controller and     |
// |               the UART byte layer. A byte moves in any cycle where both    |
// |               o_tx_valid and i_tx_ready are high.                          |
// | Ports       : o_tx_data  - byte to transmit (driven by master)             |
// |               o_tx_valid - o_tx_data is valid (driven by master)           |
// |               i_tx_ready - transmitter accepts the byte (driven by slave)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface debug_unit_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;

  modport master (
    output o_tx_data,
    output o_tx_valid,
    input  i_tx_ready
  );

  modport slave (
    input  o_tx_data,
    input  o_tx_valid,
    output i_tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/debug_word_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_word_tx                                                |
// | Description : Loads one word and sends it as bytes, most significant byte  |
// |               first, over a valid/ready handshake. Data and valid come     |
// |               straight from registers so they hold while stalled.          |
// | Ports       : i_clock, i_reset - clock, synchronous active-high reset      |
// |               i_load, i_word   - load a new word (only while idle)         |
// |               tx_if            - transmit handshake (master side)          |
// |               o_done           - pulse with the final byte transfer        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debug_word_tx
  import debug_pkg::*;
#(
  parameter int NB_WORD = 32,
  parameter int NB_BYTE = 8
) (
  input  wire logic               i_clock,
  input  wire logic               i_reset,
  input  wire logic               i_load,
  input  wire logic [NB_WORD-1:0] i_word,
  debug_unit_if.master            tx_if,
  output logic                    o_done
);

  localparam int c_N_BYTES = NB_WORD / NB_BYTE;
  localparam int c_NB_CNT  = clogb2(c_N_BYTES);
  localparam logic [c_NB_CNT-1:0] c_LAST_IDX = c_NB_CNT'(c_N_BYTES - 1);

  logic [NB_WORD-1:0]  shift_q;
  logic [c_NB_CNT-1:0] idx_q;
  logic                valid_q;
  logic                w_xfer;

  assign w_xfer           = valid_q && tx_if.i_tx_ready;
  assign o_done           = w_xfer && (idx_q == c_LAST_IDX);
  assign tx_if.o_tx_data  = shift_q[NB_WORD-1 -: NB_BYTE];
  assign tx_if.o_tx_valid = valid_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      shift_q <= i_word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (w_xfer) begin
      // Next byte moves into the top slot that feeds o_tx_data.
      shift_q <= shift_q << NB_BYTE;
      idx_q   <= idx_q + 1'b1;
      if (idx_q == c_LAST_IDX) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debug_unit                                                   |
// | Description : Host-side debug controller for the MIPS pipeline. Decodes    |
// |               command bytes (run / step / pipeline reset), gates the       |
// |               pipeline enable, counts enabled cycles and, after a run or   |
// |               step, dumps PC, cycle count, register file and the first    |
// |               data-memory words as a big-endian byte stream.               |
// | Ports       : i_clock, i_reset          - clock, sync active-high reset    |
// |               i_rx_data, i_rx_valid     - received command byte            |
// |               tx_if                     - byte transmit handshake          |
// |               o_pipe_valid, o_pipe_reset- pipeline enable / reset          |
// |               i_halt, i_pc              - pipeline halt flag, fetch PC     |
// |               o_reg_addr, i_reg_data    - regfile debug port (1-cyc lat)   |
// |               o_dmem_addr, i_dmem_data  - dmem debug port (1-cyc lat)      |
// |               o_busy                    - controller not idle              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debug_unit
  import debug_pkg::*;
#(
  parameter int NB_REG        = 32,
  parameter int NB_REG_ADDR   = 5,
  parameter int REGFILE_DEPTH = 32,
  parameter int N_DMEM_WORDS  = 32,
  parameter int NB_DMEM_ADDR  = clogb2(N_DMEM_WORDS),
  parameter int NB_BYTE       = 8
) (
  input  wire logic                    i_clock,
  input  wire logic                    i_reset,
  input  wire logic [NB_BYTE-1:0]      i_rx_data,
  input  wire logic                    i_rx_valid,
  debug_unit_if.master                 tx_if,
  output logic                         o_pipe_valid,
  output logic                         o_pipe_reset,
  input  wire logic                    i_halt,
  input  wire logic [NB_REG-1:0]       i_pc,
  output logic [NB_REG_ADDR-1:0]       o_reg_addr,
  input  wire logic [NB_REG-1:0]       i_reg_data,
  output logic [NB_DMEM_ADDR-1:0]      o_dmem_addr,
  input  wire logic [NB_REG-1:0]       i_dmem_data,
  output logic                         o_busy
);

  localparam int c_WIDX_LAST_INT = WIDX_REG0 + REGFILE_DEPTH + N_DMEM_WORDS - 1;
  localparam int NB_WIDX         = clogb2(c_WIDX_LAST_INT + 2);

  localparam logic [NB_WIDX-1:0] c_WIDX_PC   = NB_WIDX'(WIDX_PC);
  localparam logic [NB_WIDX-1:0] c_WIDX_CNT  = NB_WIDX'(WIDX_CNT);
  localparam logic [NB_WIDX-1:0] c_WIDX_REG0 = NB_WIDX'(WIDX_REG0);
  localparam logic [NB_WIDX-1:0] c_WIDX_MEM0 = NB_WIDX'(widx_mem0(REGFILE_DEPTH));
  localparam logic [NB_WIDX-1:0] c_WIDX_LAST = NB_WIDX'(c_WIDX_LAST_INT);

  state_t                  state_q;
  logic [NB_WIDX-1:0]      widx_q;
  logic [NB_REG_ADDR-1:0]  reg_addr_q;
  logic [NB_DMEM_ADDR-1:0] dmem_addr_q;
  logic [NB_REG-1:0]       cnt_q;
  logic [NB_REG-1:0]       cnt_d;

  logic [NB_WIDX-1:0]      w_widx_inc;
  logic [NB_REG-1:0]       w_word;
  logic                    w_load;
  logic                    w_word_done;

  // --------------------------------------------------------------------------
  // Pipeline control and status
  // --------------------------------------------------------------------------
  assign o_pipe_valid = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !i_halt;
  assign o_pipe_reset = i_reset || (state_q == ST_PRST);
  assign o_busy       = (state_q != ST_IDLE);
  assign o_reg_addr   = reg_addr_q;
  assign o_dmem_addr  = dmem_addr_q;

  // --------------------------------------------------------------------------
  // Enabled-cycle counter, saturating
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_PRST) begin
      cnt_d = '0;
    end else if (o_pipe_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Dump word selection; sampled by the serializer in CAPT
  // --------------------------------------------------------------------------
  assign w_widx_inc = widx_q + 1'b1;
  assign w_load     = (state_q == ST_CAPT);

  always_comb begin
    w_word = i_dmem_data;
    if (widx_q == c_WIDX_PC) begin
      w_word = i_pc;
    end else if (widx_q == c_WIDX_CNT) begin
      w_word = cnt_q;
    end else if (widx_q < c_WIDX_MEM0) begin
      w_word = i_reg_data;
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM and read-address sequencing.
  // The read address for word w+1 is registered while capturing word w, so it
  // is already on the port during the following LOAD cycle and the 1-cycle
  // read data is ready in CAPT. Only the address of the active region moves.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      reg_addr_q  <= '0;
      dmem_addr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_RUN:  state_q <= ST_RUN;
              CMD_STEP: state_q <= ST_STEP;
              CMD_PRST: state_q <= ST_PRST;
              default:  state_q <= ST_IDLE;
            endcase
          end
        end
        ST_RUN: begin
          if (i_halt) begin
            state_q <= ST_LOAD;
            widx_q  <= '0;
          end
        end
        ST_STEP: begin
          state_q <= ST_LOAD;
          widx_q  <= '0;
        end
        ST_PRST: begin
          state_q <= ST_IDLE;
        end
        ST_LOAD: begin
          state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          state_q <= ST_SEND;
          if ((w_widx_inc >= c_WIDX_REG0) && (w_widx_inc < c_WIDX_MEM0)) begin
            reg_addr_q <= NB_REG_ADDR'(w_widx_inc - c_WIDX_REG0);
          end else if ((w_widx_inc >= c_WIDX_MEM0) && (widx_q != c_WIDX_LAST)) begin
            dmem_addr_q <= NB_DMEM_ADDR'(w_widx_inc - c_WIDX_MEM0);
          end
        end
        ST_SEND: begin
          if (w_word_done) begin
            if (widx_q == c_WIDX_LAST) begin
              state_q <= ST_IDLE;
              widx_q  <= '0;
            end else begin
              state_q <= ST_LOAD;
              widx_q  <= w_widx_inc;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word serializer
  // --------------------------------------------------------------------------
  debug_word_tx #(
    .NB_WORD (NB_REG),
    .NB_BYTE (NB_BYTE)
  ) u_word_tx (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_word  (w_word),
    .tx_if   (tx_if),
    .o_done  (w_word_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_debug_unit                                                |
// | Description : Directed bench for debug_unit with a small pipeline model    |
// |               (PC advancing on enable, halt at a chosen PC) and 1-cycle    |
// |               register file / data memory read ports.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_debug_unit;

  localparam int DUMP_BYTES = 264;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        pipe_valid;
  logic        pipe_reset;
  logic        halt;
  logic        halt_en;
  logic        halt_force;
  logic [31:0] pc_q = '0;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data = '0;
  logic [4:0]  dmem_addr;
  logic [31:0] dmem_data = '0;
  logic        busy;

  logic [31:0] regs [32];
  logic [31:0] mem  [32];

  logic [7:0]  rx_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  run_q [$];
  int          en_cnt = 0;
  int          stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  debug_unit_if #(.NB_BYTE(8)) tx_if ();

  debug_unit dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .tx_if        (tx_if),
    .o_pipe_valid (pipe_valid),
    .o_pipe_reset (pipe_reset),
    .i_halt       (halt),
    .i_pc         (pc_q),
    .o_reg_addr   (reg_addr),
    .i_reg_data   (reg_data),
    .o_dmem_addr  (dmem_addr),
    .i_dmem_data  (dmem_data),
    .o_busy       (busy)
  );

  // Pipeline model: PC moves by 4 per enabled cycle; halts at PC 40 when armed.
  assign halt = halt_force | (halt_en & (pc_q == 32'd40));

  always @(posedge clk) begin
    if (pipe_reset) pc_q <= '0;
    else if (pipe_valid) pc_q <= pc_q + 32'd4;
    reg_data  <= regs[reg_addr];
    dmem_data <= mem[dmem_addr];
  end

  // Transfer capture, enable count, stall stability monitor.
  always @(posedge clk) begin
    if (tx_if.o_tx_valid && tx_if.i_tx_ready) rx_q.push_back(tx_if.o_tx_data);
    if (pipe_valid) en_cnt <= en_cnt + 1;
    if (prev_stall && (!tx_if.o_tx_valid || (tx_if.o_tx_data !== prev_data)))
      stall_viol <= stall_viol + 1;
    prev_stall <= tx_if.o_tx_valid && !tx_if.i_tx_ready;
    prev_data  <= tx_if.o_tx_data;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void build_exp(input logic [31:0] pc, input logic [31:0] cnt);
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < 66; i++) begin
      if (i == 0) w = pc;
      else if (i == 1) w = cnt;
      else if (i < 34) w = regs[i-2];
      else w = mem[i-34];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
  endfunction

  function automatic logic [7:0] byte_at(input int idx);
    logic [7:0] r = 8'hxx;
    if (idx >= 0 && idx < rx_q.size()) r = rx_q[idx];
    return r;
  endfunction

  function automatic logic [31:0] word_at(input int base, input int w);
    return {byte_at(base + 4*w), byte_at(base + 4*w + 1),
            byte_at(base + 4*w + 2), byte_at(base + 4*w + 3)};
  endfunction

  // Index of the first received byte (from base) that differs from exp_q, or -1.
  function automatic int first_diff(input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= rx_q.size()) return i;
      if (rx_q[base + i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk);
    rx_data  = c;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input bit rnd);
    bit done = 1'b0;
    for (int i = 0; i < 6000 && !done; i++) begin
      @(negedge clk);
      if (rnd) tx_if.i_tx_ready = 1'($urandom_range(0, 1));
      if (!busy) done = 1'b1;
    end
    tx_if.i_tx_ready = 1'b1;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL busy_timeout: busy=%0b after 6000 cycles, want 0", busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (pipe_reset !== 1'b1) begin n_err++; $display("FAIL rst_pipe_reset: got %b want 1", pipe_reset); end
    n_cmp++; if (pipe_valid !== 1'b0) begin n_err++; $display("FAIL rst_pipe_valid: got %b want 0", pipe_valid); end
    n_cmp++; if (tx_if.o_tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid: got %b want 0", tx_if.o_tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (reg_addr !== 5'd0) begin n_err++; $display("FAIL rst_reg_addr: got %0d want 0", reg_addr); end
    n_cmp++; if (dmem_addr !== 5'd0) begin n_err++; $display("FAIL rst_dmem_addr: got %0d want 0", dmem_addr); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (pipe_reset !== 1'b0) begin n_err++; $display("FAIL rst_release: pipe_reset got %b want 0", pipe_reset); end
  endtask

  task automatic test_prst();
    int base = rx_q.size();
    send_cmd(8'h72);
    n_cmp++; if (pipe_reset !== 1'b1) begin n_err++; $display("FAIL prst_pulse: got %b want 1", pipe_reset); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL prst_busy: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++; if (pipe_reset !== 1'b0) begin n_err++; $display("FAIL prst_one_cycle: got %b want 0", pipe_reset); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL prst_idle: busy got %b want 0", busy); end
    repeat (10) @(negedge clk);
    n_cmp++; if (rx_q.size() - base != 0) begin n_err++; $display("FAIL prst_no_bytes: got %0d want 0", rx_q.size() - base); end
    // Counter cleared: a suppressed step dumps count 0.
    halt_force = 1'b1;
    base = rx_q.size();
    send_cmd(8'h73);
    wait_idle(1'b0);
    halt_force = 1'b0;
    n_cmp++; if (word_at(base, 1) !== 32'd0) begin n_err++; $display("FAIL prst_count: got %h want 00000000", word_at(base, 1)); end
  endtask

  task automatic test_run();
    int base = rx_q.size();
    int en0 = en_cnt;
    int d;
    halt_en = 1'b1;
    send_cmd(8'h63);
    n_cmp++; if (pipe_valid !== 1'b1) begin n_err++; $display("FAIL run_valid_t1: got %b want 1", pipe_valid); end
    wait_idle(1'b0);
    halt_en = 1'b0;
    n_cmp++; if (en_cnt - en0 != 10) begin n_err++; $display("FAIL run_enables: got %0d want 10", en_cnt - en0); end
    n_cmp++; if (rx_q.size() - base != DUMP_BYTES) begin n_err++; $display("FAIL run_len: got %0d want %0d", rx_q.size() - base, DUMP_BYTES); end
    n_cmp++; if (word_at(base, 1) !== 32'h0000_000A) begin n_err++; $display("FAIL run_count: got %h want 0000000a", word_at(base, 1)); end
    n_cmp++; if (word_at(base, 2) !== 32'h0000_0000) begin n_err++; $display("FAIL run_reg0: got %h want 00000000", word_at(base, 2)); end
    build_exp(32'd40, 32'd10);
    d = first_diff(base);
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL run_stream: byte %0d got %h want %h", d, byte_at(base + d), exp_q[d]); end
    run_q.delete();
    for (int i = 0; i < DUMP_BYTES; i++) run_q.push_back(byte_at(base + i));
  endtask

  task automatic test_step3();
    send_cmd(8'h72);
    for (int k = 1; k <= 3; k++) begin
      int base = rx_q.size();
      int en0 = en_cnt;
      int d;
      send_cmd(8'h73);
      n_cmp++; if (pipe_valid !== 1'b1) begin n_err++; $display("FAIL step%0d_valid: got %b want 1", k, pipe_valid); end
      wait_idle(1'b0);
      n_cmp++; if (en_cnt - en0 != 1) begin n_err++; $display("FAIL step%0d_enables: got %0d want 1", k, en_cnt - en0); end
      n_cmp++; if (word_at(base, 1) !== 32'(k)) begin n_err++; $display("FAIL step%0d_count: got %h want %h", k, word_at(base, 1), 32'(k)); end
      build_exp(32'(4*k), 32'(k));
      d = first_diff(base);
      n_cmp++; if (d != -1 || rx_q.size() - base != DUMP_BYTES) begin
        n_err++; $display("FAIL step%0d_stream: len %0d byte %0d got %h want %h", k, rx_q.size() - base, d, byte_at(base + d), (d >= 0) ? exp_q[d] : 8'h00);
      end
    end
  endtask

  task automatic test_backpressure();
    int base;
    int s0;
    int d;
    send_cmd(8'h72);
    s0 = stall_viol;
    base = rx_q.size();
    halt_en = 1'b1;
    send_cmd(8'h63);
    wait_idle(1'b1);
    halt_en = 1'b0;
    n_cmp++; if (rx_q.size() - base != DUMP_BYTES) begin n_err++; $display("FAIL bp_len: got %0d want %0d", rx_q.size() - base, DUMP_BYTES); end
    exp_q = run_q;
    d = first_diff(base);
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL bp_stream: byte %0d got %h want %h", d, byte_at(base + d), exp_q[d]); end
    n_cmp++; if (stall_viol - s0 != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_viol - s0); end
  endtask

  task automatic test_ignore();
    int base;
    int en0;
    int d;
    send_cmd(8'h72);
    base = rx_q.size();
    en0 = en_cnt;
    send_cmd(8'h73);
    repeat (20) @(negedge clk);
    send_cmd(8'h73);
    wait_idle(1'b0);
    n_cmp++; if (en_cnt - en0 != 1) begin n_err++; $display("FAIL ign_enables: got %0d want 1", en_cnt - en0); end
    n_cmp++; if (rx_q.size() - base != DUMP_BYTES) begin n_err++; $display("FAIL ign_len: got %0d want %0d", rx_q.size() - base, DUMP_BYTES); end
    // Unknown code stays idle.
    send_cmd(8'h78);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL unknown_cmd: busy got %b want 0", busy); end
    // Step while halted: no enable, full dump, state unchanged (pc 4, count 1).
    halt_force = 1'b1;
    base = rx_q.size();
    en0 = en_cnt;
    send_cmd(8'h73);
    n_cmp++; if (pipe_valid !== 1'b0) begin n_err++; $display("FAIL halt_step_valid: got %b want 0", pipe_valid); end
    wait_idle(1'b0);
    halt_force = 1'b0;
    n_cmp++; if (en_cnt - en0 != 0) begin n_err++; $display("FAIL halt_step_enables: got %0d want 0", en_cnt - en0); end
    build_exp(32'd4, 32'd1);
    d = first_diff(base);
    n_cmp++; if (d != -1 || rx_q.size() - base != DUMP_BYTES) begin
      n_err++; $display("FAIL halt_step_stream: len %0d byte %0d got %h want %h", rx_q.size() - base, d, byte_at(base + d), (d >= 0) ? exp_q[d] : 8'h00);
    end
  endtask

  task automatic test_reset_abort();
    int base = rx_q.size();
    int d;
    bit hit = 1'b0;
    send_cmd(8'h73);
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (rx_q.size() - base == 100) hit = 1'b1;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL abort_reach100: got %0d bytes want 100", rx_q.size() - base); end
    rst = 1'b1;
    tx_if.i_tx_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx_if.o_tx_valid !== 1'b0) begin n_err++; $display("FAIL abort_tx_valid: got %b want 0", tx_if.o_tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle: busy got %b want 0", busy); end
    rst = 1'b0;
    tx_if.i_tx_ready = 1'b1;
    repeat (30) @(negedge clk);
    n_cmp++; if (rx_q.size() - base != 100) begin n_err++; $display("FAIL abort_no_more: got %0d bytes want 100", rx_q.size() - base); end
    // Counter and PC cleared by the reset.
    halt_force = 1'b1;
    base = rx_q.size();
    send_cmd(8'h73);
    wait_idle(1'b0);
    halt_force = 1'b0;
    n_cmp++; if (word_at(base, 1) !== 32'd0) begin n_err++; $display("FAIL abort_count: got %h want 00000000", word_at(base, 1)); end
    build_exp(32'd0, 32'd0);
    d = first_diff(base);
    n_cmp++; if (d != -1) begin n_err++; $display("FAIL abort_dump: byte %0d got %h want %h", d, byte_at(base + d), exp_q[d]); end
  endtask

  initial begin
    rst        = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    halt_en    = 1'b0;
    halt_force = 1'b0;
    tx_if.i_tx_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'(i) * 32'h0101_0101;
      mem[i]  = 32'hDEAD_0000 | 32'(i);
    end
    test_reset();
    test_prst();
    test_run();
    test_step3();
    test_backpressure();
    test_ignore();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_unit.md
# debug_unit

Host-side debug controller for the MIPS pipeline. It takes command bytes from a byte receiver and gates the pipeline enable for continuous run, single step or pipeline reset. It counts enabled cycles. After a run or step completes, it reads the PC, the cycle count, the register file and the first data-memory words through registered read ports, and streams them out as bytes over a valid/ready transmit handshake. It sits between the UART byte layer and the `pipeline` top.

## Interface
- `NB_REG`, 32, data word width
- `NB_REG_ADDR`, 5, register file address width
- `REGFILE_DEPTH`, 32, number of registers dumped
- `N_DMEM_WORDS`, 32, data-memory words dumped, starting at word address 0
- `NB_DMEM_ADDR`, clogb2(N_DMEM_WORDS), data-memory word address width
- `NB_BYTE`, 8, command/transmit byte width

Ports (name, direction, width, meaning):
- `i_clock` in 1: the single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_data` in NB_BYTE: received command byte.
- `i_rx_valid` in 1: one-cycle pulse; `i_rx_data` is valid.
- `o_tx_data` out NB_BYTE: byte to transmit.
- `o_tx_valid` out 1: `o_tx_data` is valid.
- `i_tx_ready` in 1: transmitter accepts the byte. A transfer happens in a cycle with valid and ready both high.
- `o_pipe_valid` out 1: pipeline stage enable.
- `o_pipe_reset` out 1: pipeline reset, equal to `i_reset` OR the command pulse.
- `i_halt` in 1: pipeline has decoded a halt instruction.
- `i_pc` in NB_REG: current fetch PC.
- `o_reg_addr` out NB_REG_ADDR: register file debug read address.
- `i_reg_data` in NB_REG: register read data, 1-cycle latency.
- `o_dmem_addr` out NB_DMEM_ADDR: data-memory debug read address.
- `i_dmem_data` in NB_REG: data-memory read data, 1-cycle latency.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
- Commands are accepted only in IDLE. Bytes received in any other state are dropped, and so are unknown codes.
  - 0x63 'c' → RUN.
  - 0x73 's' → STEP.
  - 0x72 'r' → PRST.
- States: IDLE, RUN, STEP, PRST, LOAD, CAPT, SEND.
- `o_pipe_valid` = (state==RUN && !i_halt) || (state==STEP && !i_halt).
- RUN: stay while `i_halt`=0. On `i_halt`=1, go to LOAD with word index 0. If `i_halt` is already 1 on entry, zero cycles are enabled.
- STEP: lasts exactly one cycle, then goes to LOAD. If `i_halt`=1 the step is suppressed and the dump still occurs.
- PRST: one cycle. `o_pipe_reset`=1, cycle counter cleared, return to IDLE. No dump.
- Cycle counter: 32 bits. Increments on every cycle with `o_pipe_valid`=1 and saturates at 0xFFFF_FFFF. Cleared by `i_reset` and PRST.
- Dump sequence by word index w:
  - w=0: PC.
  - w=1: cycle count.
  - w=2..REGFILE_DEPTH+1: register w-2.
  - next N_DMEM_WORDS indices: memory word 0..N_DMEM_WORDS-1.
- LOAD drives the read address for w. The address is `o_reg_addr`=w-2 or `o_dmem_addr`=w-2-REGFILE_DEPTH; the other address is held.
- CAPT latches the word into the shift register. PC and count are sampled in CAPT.
- SEND transmits 4 bytes, MSB first, with `o_tx_valid` held until each byte is accepted. After the 4th byte, go to LOAD with w+1, or to IDLE after the last word.
- Reset values: state IDLE, all outputs 0 except `o_pipe_reset`=1 while `i_reset`=1, counter 0, w 0.
- `i_reset` mid-dump: aborts immediately, nothing further is sent, and `o_tx_valid` drops in the next cycle.

## Timing
- Command byte in cycle t → state entered at t+1. For RUN/STEP, `o_pipe_valid` goes high combinationally in t+1.
- STEP produces exactly one enabled cycle.
- RUN ends in the cycle `i_halt` is seen. `o_pipe_valid` is low in that cycle.
- Per word: LOAD 1 cycle, CAPT 1 cycle, then ≥4 cycles in SEND. With `i_tx_ready` tied high this is 6 cycles per word.
- Dump length = 4·(2+REGFILE_DEPTH+N_DMEM_WORDS) bytes, 264 with defaults.
- `o_tx_data` and `o_tx_valid` come from registers. They must stay stable while `o_tx_valid`=1 and `i_tx_ready`=0.
- `o_busy` rises the cycle after the command and falls the cycle after the last byte is accepted.

## Structure
- Package `debug_pkg`:
  - command codes CMD_RUN, CMD_STEP, CMD_PRST
  - state enum
  - word-index bounds WIDX_PC, WIDX_CNT, WIDX_REG0, WIDX_MEM0
- Sub-module `debug_word_tx`:
  - 32-bit load → 4-byte MSB-first valid/ready serializer
  - `o_done` pulse on the final byte
- The top holds the FSM, cycle counter and address sequencing.

## Test plan
- Reset then 'r': `o_pipe_reset` high one cycle, counter 0, no bytes sent, `o_busy` returns 0.
- Program halts after 10 enabled cycles, send 'c':
  - exactly 10 cycles with `o_pipe_valid`=1
  - 264 bytes out
  - bytes 4..7 = 00 00 00 0A
  - bytes 8..11 = register 0 = 00 00 00 00
- 's' three times: one enable pulse each and three full dumps, with count words 1, 2, 3.
- Random `i_tx_ready` backpressure (50%) during a dump: byte stream identical to the ready-high run, and `o_tx_data` is stable while stalled.
- 's' sent during a dump is ignored: no extra enable and dump length unchanged. 's' with `i_halt`=1: zero enables, dump still sent.
- `i_reset` asserted at byte 100 of a dump: no further transfers, state IDLE, counter 0.
